// File: rtl/config_chain_loader_pkg.sv
// ----------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the configuration chain loader, the fabric top and
// the chain model used in simulation.
//   state_e           : loader FSM state encodings (fixed values, relied upon
//                       by anything that decodes DBG_STATE)
//   CHAIN_LEN_DEFAULT : default number of configuration flip-flops
//   out_t             : bundle of the loader's registered control outputs
//   bits_this_byte()  : how many bits of the next byte are actually shifted
//   outputs_for()     : control output values that belong to a state
// ----------------------------------------------------------------------------
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BYTE = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam int unsigned CHAIN_LEN_DEFAULT = 1024;

  typedef struct packed {
    logic byte_ready;
    logic ccff_en;
    logic fab_rst;
    logic busy;
    logic done;
  } out_t;

  // Bits still to go in the chain, capped at one byte. Only called with a
  // non-zero remainder, since a full chain leaves WAIT_BYTE for good.
  function automatic logic [3:0] bits_this_byte(input int unsigned remaining);
    if (remaining >= 32'd8) begin
      return 4'd8;
    end
    return 4'(remaining);
  endfunction

  // The fabric is held in reset in every state except DONE.
  function automatic out_t outputs_for(input state_e s);
    out_t o;
    o.byte_ready = (s == ST_WAIT_BYTE);
    o.ccff_en    = (s == ST_SHIFT);
    o.fab_rst    = (s != ST_DONE);
    o.busy       = (s == ST_WAIT_BYTE) || (s == ST_SHIFT);
    o.done       = (s == ST_DONE);
    return o;
  endfunction

endpackage

// File: rtl/config_chain_loader_byte_piso.sv
// ----------------------------------------------------------------------------
// byte_piso
// 8-bit parallel-load, serial-out shift register. Shifts right, so bit 0 of
// the loaded byte appears first on q0_o. Zeros fill from the top.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset (clears the register)
//   load_i  : load d_i (takes priority over shift_i)
//   shift_i : shift right by one
//   d_i     : parallel data
//   q0_o    : current bit 0 (the bit being presented)
// ----------------------------------------------------------------------------
module byte_piso (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [7:0] d_i,
  output logic       q0_o
);

  logic [7:0] sreg_q, sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = d_i;
    end else if (shift_i) begin
      sreg_d = {1'b0, sreg_q[7:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign q0_o = sreg_q[0];

endmodule

// File: rtl/config_chain_loader.sv
// ----------------------------------------------------------------------------
// config_chain_loader
// Writer side of the fabric configuration chain. Takes bitstream bytes from
// the host, shifts them LSB first into the chain head, counts exactly
// CHAIN_LEN bits, keeps the fabric in reset while loading and releases it
// once the chain is full.
//   CK         : clock shared with the configuration chain
//   RSTN       : synchronous active-low reset
//   START      : begin a load (honoured in IDLE or DONE only)
//   ABORT      : cancel a load in progress (wins over START)
//   BYTE_IN    : bitstream byte, bit 0 shifted first
//   BYTE_VALID : BYTE_IN is valid
//   BYTE_READY : loader accepts a byte this cycle
//   CCFF_HEAD  : serial data to the chain head
//   CCFF_EN    : chain shift enable, one chain bit per CK edge while high
//   FAB_RST    : active-high fabric reset
//   BUSY       : load in progress
//   DONE       : chain fully loaded, fabric released
//   DBG_STATE  : current FSM state (cfg_pkg::state_e encoding)
//
// Byte handshake: a byte transfers on a CK edge where BYTE_VALID and
// BYTE_READY are both 1. BYTE_READY is registered and only depends on the
// state, never on BYTE_VALID; the host may hold BYTE_VALID low as long as it
// likes. An ABORT in the same cycle drops the byte.
// ----------------------------------------------------------------------------
module config_chain_loader
  import cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       CK,
  input  logic       RSTN,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  output logic       BYTE_READY,
  output logic       CCFF_HEAD,
  output logic       CCFF_EN,
  output logic       FAB_RST,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] DBG_STATE
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // bits shifted into the chain so far
  logic [3:0]       nbits_q, nbits_d; // bits of the current byte still to shift
  out_t             out_q, out_d;
  logic             load, shift, handshake;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nbits_d   = nbits_q;
    load      = 1'b0;
    shift     = 1'b0;
    handshake = BYTE_VALID && out_q.byte_ready;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START && !ABORT) begin
          state_d = ST_WAIT_BYTE;
          cnt_d   = '0;
        end
      end
      ST_WAIT_BYTE: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (handshake) begin
          load    = 1'b1;
          // On the final byte only the bits that still fit are shifted;
          // the rest of the byte is simply left in the register.
          nbits_d = bits_this_byte(CHAIN_LEN - 32'(cnt_q));
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else begin
          shift   = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          nbits_d = nbits_q - 4'd1;
          if (nbits_q == 4'd1) begin
            state_d = (32'(cnt_q) + 32'd1 == CHAIN_LEN) ? ST_DONE : ST_WAIT_BYTE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the
    // state they describe without any input-to-output path.
    out_d = outputs_for(state_d);
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      nbits_q <= '0;
      out_q   <= outputs_for(ST_IDLE);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nbits_q <= nbits_d;
      out_q   <= out_d;
    end
  end

  byte_piso u_piso (
    .clk_i   (CK),
    .rst_ni  (RSTN),
    .load_i  (load),
    .shift_i (shift),
    .d_i     (BYTE_IN),
    .q0_o    (CCFF_HEAD)
  );

  assign BYTE_READY = out_q.byte_ready;
  assign CCFF_EN    = out_q.ccff_en;
  assign FAB_RST    = out_q.fab_rst;
  assign BUSY       = out_q.busy;
  assign DONE       = out_q.done;
  assign DBG_STATE  = state_q;

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Writer side of the fabric configuration chain. Accepts bitstream bytes from the host-facing port over a valid/ready handshake and serializes them, LSB first, into the head of the scan chain of reset flip-flops. It counts exactly `CHAIN_LEN` bits, holds the fabric in reset while loading, and releases it when the chain is full. It sits between the top-level pin interface and the configuration chain's head, shift-enable and fabric-reset nets.

## Interface
- `CHAIN_LEN`, default 1024: number of configuration flip-flops in the chain (≥1).
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: bit-counter width.

Ports:
- `CK` in 1: single clock, shared with the configuration chain.
- `RSTN` in 1: reset. **Synchronous, active-low.**
- `START` in 1: begin a load. One-cycle pulse, sampled only in IDLE or DONE.
- `ABORT` in 1: cancel a load in progress.
- `BYTE_IN` in 8: bitstream byte. Bit 0 is shifted first.
- `BYTE_VALID` in 1: `BYTE_IN` is valid.
- `BYTE_READY` out 1: loader accepts a byte this cycle.
- `CCFF_HEAD` out 1: serial data to the chain head.
- `CCFF_EN` out 1: chain shift enable, gating the chain clock. The chain advances one bit on each `CK` edge where this is 1.
- `FAB_RST` out 1: active-high fabric reset. Drives the fabric flip-flops' RST.
- `BUSY` out 1: load in progress.
- `DONE` out 1: chain is fully loaded and the fabric is released.

## Operation
- States: IDLE, WAIT_BYTE, SHIFT, DONE.
- Reset values (`RSTN`=0 at a `CK` edge): state=IDLE, `BYTE_READY`=0, `CCFF_EN`=0, `CCFF_HEAD`=0, `FAB_RST`=1, `BUSY`=0, `DONE`=0, bit counter=0, shift register=0.
- IDLE/DONE + `START`: go to WAIT_BYTE, clear the bit counter, `FAB_RST`=1, `DONE`=0, `BUSY`=1.
- WAIT_BYTE: `BYTE_READY`=1.
  - On `BYTE_VALID && BYTE_READY`, capture `BYTE_IN` into an 8-bit shift register.
  - Set bits-this-byte = min(8, `CHAIN_LEN` − count) and go to SHIFT.
- SHIFT: `BYTE_READY`=0, `CCFF_EN`=1, `CCFF_HEAD`=sreg[0].
  - Each cycle: shift the register right by one and increment the counter.
  - After bits-this-byte cycles: if count==`CHAIN_LEN`, go to DONE; otherwise return to WAIT_BYTE.
- Partial last byte: when `CHAIN_LEN` mod 8 ≠ 0, the upper bits of the final byte are discarded, never shifted.
- DONE: `FAB_RST`=0, `DONE`=1, `BUSY`=0, `CCFF_EN`=0. Bytes are not accepted (`BYTE_READY`=0).
- `ABORT` in WAIT_BYTE or SHIFT: go to IDLE next cycle.
  - `CCFF_EN`=0 immediately (registered), `FAB_RST` stays 1, `DONE`=0.
  - The partially loaded chain content is undefined.
- `ABORT` in IDLE or DONE has no effect.
- `START` while `BUSY` is ignored.
- `ABORT` and `START` in the same cycle: `ABORT` wins. `START` is not remembered.
- `RSTN` low mid-load: same as reset. No shifting after that edge.
- No underrun timeout. WAIT_BYTE waits indefinitely for the host.

## Timing
- All outputs are registered. No combinational path from input to output.
- `START` at edge n puts the loader in WAIT_BYTE; `BYTE_READY`=1 after edge n.
- Byte handshake at edge m: `CCFF_EN`=1 and `CCFF_HEAD`=`BYTE_IN`[0] during cycle m+1; the chain captures that bit at edge m+1. Bit k is presented in cycle m+1+k.
- Throughput: 9 cycles per full byte (1 handshake + 8 shift). No overlap between handshake and shifting.
- Total load time with zero host stall: ceil(`CHAIN_LEN`/8) + `CHAIN_LEN` cycles after WAIT_BYTE entry.
- `DONE`=1 and `FAB_RST`=0 in the cycle after the last shift cycle.
- The counter never exceeds `CHAIN_LEN`. `CNT_W` must hold the value `CHAIN_LEN`.

## Structure
- Shared package `cfg_pkg`: state encodings (IDLE=2'd0, WAIT_BYTE=2'd1, SHIFT=2'd2, DONE=2'd3) and the default `CHAIN_LEN`. The fabric top and the testbench chain model reuse it.
- One sub-module, `byte_piso`: 8-bit parallel-load/serial-out register with load, shift and `q0` output.
- The FSM and counter live in `config_chain_loader`.

## Test plan
- Reset: hold `RSTN`=0 for 2 edges -> `FAB_RST`=1, and `BYTE_READY`, `CCFF_EN`, `BUSY`, `DONE` all 0.
- Exact-multiple load, `CHAIN_LEN`=16: `START`, then bytes 0xA5 and 0x3C with no stall.
  - Required: `CCFF_EN` high for exactly 16 cycles.
  - Required head sequence: 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - Required: 16-FF chain model reads 0x3CA5 (first bit at tail); `DONE`=1 on cycle 19 after WAIT_BYTE entry.
- Partial byte, `CHAIN_LEN`=12: bytes 0xFF and 0x0F -> 12 shift cycles total, 0x0FFF loaded, then `DONE`. The second byte shifts only 4 bits.
- Host stall: `BYTE_VALID` low 5 cycles between bytes -> `CCFF_EN` stays 0 during the stall and the chain content is unchanged. The final result matches the no-stall case.
- Abort mid-SHIFT (after 3 bits of the first byte) -> next cycle `CCFF_EN`=0, state IDLE, `FAB_RST`=1, `DONE`=0. A new `START` then reloads correctly.
- Edge cases:
  - `START` during `BUSY` -> no effect.
  - `ABORT`+`START` in the same cycle -> IDLE.
  - `RSTN` low during SHIFT -> no further `CCFF_EN` pulses.
